// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one cache-bus port to memory between NUM_REQ cache-side
// requesters (ICache, DCache, uncached path). A grant is held for a whole
// transaction, single beat or burst, and released on the beat with ready&&last.
// The bus and response paths are pure combinational muxes, so there is no
// buffering and no added data latency while a grant is held.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  cbus_req_t                  ireqs  [NUM_REQ],
    output cbus_resp_t                 iresps [NUM_REQ],
    output cbus_req_t                  oreq,
    input  cbus_resp_t                 oresp,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   sel, sel_nxt;
    logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NUM_REQ-1:0] req_vld;
    logic [IW:0]     win;
    logic            win_vld;
    logic [IW-1:0]   win_idx;

    // Requester index after idx, wrapping at NUM_REQ (which need not be a power of two).
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // First valid requester scanning ptr, ptr+1, ... with wrap; {found, index}.
    // Fixed priority is the same scan starting from index 0.
    function automatic logic [IW:0] pick_winner(input logic [NUM_REQ-1:0] vld,
                                                input logic [IW-1:0]     ptr);
        logic [IW-1:0] cand;
        logic          found;
        logic [IW-1:0] res;
        cand  = ptr;
        found = 1'b0;
        res   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && vld[cand]) begin
                found = 1'b1;
                res   = cand;
            end
            cand = next_idx(cand);
        end
        return {found, res};
    endfunction

    // Gather the valid bits of every requester for arbitration.
    always_comb begin
        req_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vld[i] = ireqs[i].valid;
        end
    end

    assign win     = pick_winner(req_vld, (ROUND_ROBIN != 0) ? rr_ptr : '0);
    assign win_vld = win[IW];
    assign win_idx = win[IW-1:0];

    // State, grant and rotation pointer registers; reset drops any grant at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Arbitrate in IDLE; in BUSY route the granted requester to memory and back
    // until the last beat. Other requesters see all-zero responses and wait.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        oreq       = '0;
        busy       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            iresps[i] = '0;
        end
        case (state)
            IDLE: begin
                if (win_vld) begin
                    sel_nxt   = win_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                oreq        = ireqs[sel];
                iresps[sel] = oresp;
                busy        = 1'b1;
                if (oresp.ready && oresp.last) begin
                    state_nxt = IDLE;
                    if (ROUND_ROBIN != 0) begin
                        rr_ptr_nxt = next_idx(sel);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_idx = sel;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: three instances (2-port round-robin, 2-port fixed
// priority, 3-port round-robin) driven by directed vectors. Expected grants and
// response beats are queued by the stimulus and popped by per-instance monitors.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] val;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cbus_req_t  a_ireqs [2];
    cbus_resp_t a_iresps [2];
    cbus_req_t  a_oreq;
    cbus_resp_t a_oresp;
    logic       a_busy;
    logic [0:0] a_gidx;

    cbus_req_t  b_ireqs [2];
    cbus_resp_t b_iresps [2];
    cbus_req_t  b_oreq;
    cbus_resp_t b_oresp;
    logic       b_busy;
    logic [0:0] b_gidx;

    cbus_req_t  c_ireqs [3];
    cbus_resp_t c_iresps [3];
    cbus_req_t  c_oreq;
    cbus_resp_t c_oresp;
    logic       c_busy;
    logic [1:0] c_gidx;

    cbus_arbiter #(.NUM_REQ(2), .ROUND_ROBIN(1)) dut_a (
        .clk(clk), .resetn(resetn), .ireqs(a_ireqs), .iresps(a_iresps),
        .oreq(a_oreq), .oresp(a_oresp), .busy(a_busy), .grant_idx(a_gidx));

    cbus_arbiter #(.NUM_REQ(2), .ROUND_ROBIN(0)) dut_b (
        .clk(clk), .resetn(resetn), .ireqs(b_ireqs), .iresps(b_iresps),
        .oreq(b_oreq), .oresp(b_oresp), .busy(b_busy), .grant_idx(b_gidx));

    cbus_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(1)) dut_c (
        .clk(clk), .resetn(resetn), .ireqs(c_ireqs), .iresps(c_iresps),
        .oreq(c_oreq), .oresp(c_oresp), .busy(c_busy), .grant_idx(c_gidx));

    int   checks = 0;
    int   errors = 0;
    exp_t q_ga[$];
    exp_t q_ba[$];
    exp_t q_gb[$];
    exp_t q_gc[$];
    int   c_exp[3] = '{2, 0, 2};

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic cbus_req_t mkreq(logic [31:0] addr, logic [3:0] len);
        cbus_req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.size  = 3'd2;
        r.addr  = addr;
        r.len   = len;
        r.burst = (len != 4'd0) ? 2'd1 : 2'd0;
        return r;
    endfunction

    function automatic cbus_resp_t mkresp(logic last, logic [31:0] data);
        cbus_resp_t r;
        r.ready = 1'b1;
        r.last  = last;
        r.data  = data;
        return r;
    endfunction

    function automatic exp_t ex(int idx, logic [31:0] v);
        exp_t e;
        e.idx = 4'(idx);
        e.val = v;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: grant starts, response beats, and quiet ports.
    logic a_prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t g;
        if (a_busy && !a_prev_busy) begin
            chk("a_grant_expected", 128'(q_ga.size() != 0), 128'd1);
            if (q_ga.size() != 0) begin
                g = q_ga.pop_front();
                chk("a_grant_idx", 128'(a_gidx), 128'(g.idx));
                chk("a_grant_addr", 128'(a_oreq.addr), 128'(g.val));
                chk("a_grant_valid", 128'(a_oreq.valid), 128'd1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (a_iresps[i].ready) begin
                chk("a_beat_expected", 128'(q_ba.size() != 0), 128'd1);
                if (q_ba.size() != 0) begin
                    g = q_ba.pop_front();
                    chk("a_beat_port", 128'(i), 128'(g.idx));
                    chk("a_beat_data", 128'(a_iresps[i].data), 128'(g.val));
                end
            end
            if (!a_busy || i != int'(a_gidx)) begin
                chk("a_quiet_port", 128'(a_iresps[i]), 128'd0);
            end
        end
        if (!a_busy) begin
            chk("a_idle_oreq", 128'(a_oreq), 128'd0);
        end
        a_prev_busy <= a_busy;
    end

    // Monitor B: fixed priority always grants port 0; port 1 sees nothing.
    logic b_prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t g;
        if (b_busy && !b_prev_busy) begin
            chk("b_grant_expected", 128'(q_gb.size() != 0), 128'd1);
            if (q_gb.size() != 0) begin
                g = q_gb.pop_front();
                chk("b_grant_idx", 128'(b_gidx), 128'(g.idx));
                chk("b_grant_addr", 128'(b_oreq.addr), 128'(g.val));
            end
        end
        if (b_busy) begin
            chk("b_port1_starved", 128'(b_iresps[1]), 128'd0);
        end
        b_prev_busy <= b_busy;
    end

    // Monitor C: grant order on the 3-port instance.
    logic c_prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t g;
        if (c_busy && !c_prev_busy) begin
            chk("c_grant_expected", 128'(q_gc.size() != 0), 128'd1);
            if (q_gc.size() != 0) begin
                g = q_gc.pop_front();
                chk("c_grant_idx", 128'(c_gidx), 128'(g.idx));
                chk("c_grant_addr", 128'(c_oreq.addr), 128'(g.val));
            end
        end
        c_prev_busy <= c_busy;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            a_ireqs[i] = '0;
            b_ireqs[i] = '0;
        end
        for (int i = 0; i < 3; i++) c_ireqs[i] = '0;
        a_oresp = '0;
        b_oresp = '0;
        c_oresp = '0;

        // Reset holds everything idle even with a request pending.
        a_ireqs[0] = mkreq(32'h0000_0100, 4'd0);
        repeat (3) step();
        #2;
        chk("rst_busy", 128'(a_busy), 128'd0);
        chk("rst_oreq", 128'(a_oreq), 128'd0);
        chk("rst_gidx", 128'(a_gidx), 128'd0);
        chk("rst_iresp1", 128'(a_iresps[1]), 128'd0);
        a_ireqs[0] = '0;
        step();
        resetn = 1'b1;
        step();
        step();

        // Single requester, single beat.
        a_ireqs[1] = mkreq(32'h8000_0040, 4'd0);
        q_ga.push_back(ex(1, 32'h8000_0040));
        #2;
        chk("t1_c0_no_grant_yet", 128'(a_oreq.valid), 128'd0);
        step();
        #2;
        chk("t1_c1_oreq_valid", 128'(a_oreq.valid), 128'd1);
        chk("t1_c1_oreq_addr", 128'(a_oreq.addr), 128'h8000_0040);
        step();
        step();
        a_oresp = mkresp(1'b1, 32'hD0D0_0001);
        q_ba.push_back(ex(1, 32'hD0D0_0001));
        #2;
        chk("t1_c3_ready", 128'(a_iresps[1].ready), 128'd1);
        step();
        a_oresp    = '0;
        a_ireqs[1] = '0;
        #2;
        chk("t1_c4_busy_low", 128'(a_busy), 128'd0);
        step();

        // 16-beat burst from port 0; port 1 becomes valid at beat 3 and waits.
        a_ireqs[0] = mkreq(32'h0000_1000, 4'd15);
        q_ga.push_back(ex(0, 32'h0000_1000));
        step();
        for (int k = 1; k <= 16; k++) begin
            a_oresp = mkresp(k == 16, 32'hB000_0000 + 32'(k));
            q_ba.push_back(ex(0, 32'hB000_0000 + 32'(k)));
            if (k == 3) begin
                a_ireqs[1] = mkreq(32'h0000_2000, 4'd0);
                q_ga.push_back(ex(1, 32'h0000_2000));
            end
            #2;
            chk("t2_grant_held", 128'(a_gidx), 128'd0);
            step();
        end
        a_oresp    = '0;
        a_ireqs[0] = '0;
        #2;
        chk("t2_idle_gap", 128'(a_busy), 128'd0);
        step();
        #2;
        chk("t2_next_busy", 128'(a_busy), 128'd1);
        chk("t2_next_idx", 128'(a_gidx), 128'd1);
        a_oresp = mkresp(1'b1, 32'hC000_0001);
        q_ba.push_back(ex(1, 32'hC000_0001));
        step();
        a_oresp    = '0;
        a_ireqs[1] = '0;
        step();

        // Round-robin contention: grants alternate 0,1,0,1 with an idle cycle between.
        a_ireqs[0] = mkreq(32'h0000_3000, 4'd0);
        a_ireqs[1] = mkreq(32'h0000_3100, 4'd0);
        for (int k = 0; k < 4; k++) begin
            q_ga.push_back(ex(k % 2, (k % 2 == 1) ? 32'h0000_3100 : 32'h0000_3000));
        end
        for (int k = 0; k < 4; k++) begin
            step();
            #2;
            chk("t3_rr_idx", 128'(a_gidx), 128'(k % 2));
            chk("t3_rr_busy", 128'(a_busy), 128'd1);
            a_oresp = mkresp(1'b1, 32'hA000_0000 + 32'(k));
            q_ba.push_back(ex(k % 2, 32'hA000_0000 + 32'(k)));
            step();
            a_oresp = '0;
            if (k == 3) begin
                a_ireqs[0] = '0;
                a_ireqs[1] = '0;
            end
            #2;
            chk("t3_idle_between", 128'(a_busy), 128'd0);
        end
        step();

        // Fixed priority: port 0 wins every time and port 1 starves by design.
        b_ireqs[0] = mkreq(32'h0000_7000, 4'd0);
        b_ireqs[1] = mkreq(32'h0000_7100, 4'd0);
        for (int k = 0; k < 3; k++) q_gb.push_back(ex(0, 32'h0000_7000));
        for (int k = 0; k < 3; k++) begin
            step();
            #2;
            chk("t4_fixed_idx", 128'(b_gidx), 128'd0);
            b_oresp = mkresp(1'b1, 32'h7700_0000 + 32'(k));
            step();
            b_oresp = '0;
            if (k == 2) begin
                b_ireqs[0] = '0;
                b_ireqs[1] = '0;
            end
            #2;
            chk("t4_idle_between", 128'(b_busy), 128'd0);
        end
        step();

        // Async reset mid-burst; rr_ptr is 1 beforehand so a restart from 0 is visible.
        a_ireqs[0] = mkreq(32'h0000_4000, 4'd0);
        q_ga.push_back(ex(0, 32'h0000_4000));
        step();
        a_oresp = mkresp(1'b1, 32'h4400_0001);
        q_ba.push_back(ex(0, 32'h4400_0001));
        step();
        a_oresp    = '0;
        a_ireqs[0] = mkreq(32'h0000_5000, 4'd7);
        q_ga.push_back(ex(0, 32'h0000_5000));
        step();
        for (int k = 1; k <= 4; k++) begin
            a_oresp = mkresp(1'b0, 32'h5500_0000 + 32'(k));
            q_ba.push_back(ex(0, 32'h5500_0000 + 32'(k)));
            step();
        end
        a_oresp = mkresp(1'b0, 32'h5500_0005);
        #1;
        resetn = 1'b0;
        #1;
        chk("t5_rst_oreq_valid", 128'(a_oreq.valid), 128'd0);
        chk("t5_rst_busy", 128'(a_busy), 128'd0);
        chk("t5_rst_iresp_ready", 128'(a_iresps[0].ready), 128'd0);
        a_oresp    = '0;
        a_ireqs[0] = '0;
        step();
        step();
        resetn = 1'b1;
        step();
        a_ireqs[0] = mkreq(32'h0000_6000, 4'd0);
        a_ireqs[1] = mkreq(32'h0000_6100, 4'd0);
        q_ga.push_back(ex(0, 32'h0000_6000));
        step();
        #2;
        chk("t5_restart_idx", 128'(a_gidx), 128'd0);
        a_oresp = mkresp(1'b1, 32'h6600_0001);
        q_ba.push_back(ex(0, 32'h6600_0001));
        step();
        a_oresp    = '0;
        a_ireqs[0] = '0;
        a_ireqs[1] = '0;
        step();

        // Three ports: grant 1, then with 0 and 2 valid the order is 2, 0 (wrap), 2.
        c_ireqs[1] = mkreq(32'h0000_8100, 4'd0);
        q_gc.push_back(ex(1, 32'h0000_8100));
        step();
        #2;
        chk("t6_first_idx", 128'(c_gidx), 128'd1);
        c_oresp = mkresp(1'b1, 32'h8800_0001);
        step();
        c_oresp    = '0;
        c_ireqs[1] = '0;
        c_ireqs[0] = mkreq(32'h0000_8000, 4'd0);
        c_ireqs[2] = mkreq(32'h0000_8200, 4'd0);
        for (int k = 0; k < 3; k++) begin
            q_gc.push_back(ex(c_exp[k], (c_exp[k] == 2) ? 32'h0000_8200 : 32'h0000_8000));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            #2;
            chk("t6_wrap_idx", 128'(c_gidx), 128'(c_exp[k]));
            c_oresp = mkresp(1'b1, 32'h8800_0010 + 32'(k));
            step();
            c_oresp = '0;
            if (k == 2) begin
                c_ireqs[0] = '0;
                c_ireqs[2] = '0;
            end
        end
        step();
        step();

        chk("end_a_grants_consumed", 128'(q_ga.size()), 128'd0);
        chk("end_a_beats_consumed", 128'(q_ba.size()), 128'd0);
        chk("end_b_grants_consumed", 128'(q_gb.size()), 128'd0);
        chk("end_c_grants_consumed", 128'(q_gc.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares one cache-bus (cbus) port to memory between NUM_REQ cache-side requesters, e.g. ICache (index 0) and DCache (index 1), or an uncached path.
- Sits between the cache controllers and the AXI/cbus bridge at the CPU top.
- Grants one requester at a time and holds the grant for a whole transaction, single beat or burst, until the final beat.
- Selection between contending requesters is round-robin or fixed priority.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- ireqs  input  NUM_REQ x cbus_req_t  requester requests (valid, is_write, size, addr, strobe, data, len, burst).
- iresps  output  NUM_REQ x cbus_resp_t  per-requester responses (ready, last, data).
- oreq  output  cbus_req_t  request to the memory-side cbus.
- oresp  input  cbus_resp_t  response from the memory-side cbus.
- busy  output  1  high while a grant is held.
- grant_idx  output  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- State machine has two states, IDLE and BUSY. Reset (resetn=0, asynchronous) forces IDLE, sel=0, rr_ptr=0.
- Reset values: oreq all fields 0 (valid=0), iresps all 0, busy=0, grant_idx=0.
- IDLE:
  - oreq is driven to all-zero and every iresps[i] is all-zero.
  - If any ireqs[i].valid is high, pick a winner, register sel=winner, and move to BUSY on the next edge.
  - The grant costs exactly 1 cycle of latency: oreq.valid rises the cycle after the first ireqs valid.
- Winner selection:
  - ROUND_ROBIN=1: first valid index scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - ROUND_ROBIN=0: lowest valid index.
- BUSY:
  - oreq = ireqs[sel] (combinational passthrough of all fields).
  - iresps[sel] = oresp. All other iresps = 0; non-granted requesters see ready=0 and simply wait.
  - busy=1 and grant_idx=sel.
- Leaving BUSY:
  - On oresp.ready && oresp.last, go to IDLE at that edge.
  - If ROUND_ROBIN=1, rr_ptr <= (sel+1) mod NUM_REQ.
  - The next arbitration happens in the following IDLE cycle, so there is always at least one idle cycle between transactions. No back-to-back re-grant occurs in the same cycle as last.
- Bursts and single beats:
  - oresp.ready without last (burst data beats) keeps BUSY.
  - A single-beat transfer has last=1 on its only ready beat.
- Requester contract: ireqs[sel] must stay valid with stable fields until it sees ready&&last. The arbiter does not re-check validity in BUSY.
  - If ireqs[sel].valid drops mid-transaction, oreq.valid follows it (passthrough).
  - The grant is still held until ready&&last. No other requester is granted meanwhile.
- Simultaneous events:
  - A new valid on another port during BUSY is ignored until IDLE.
  - Requesters that were valid in IDLE but lost arbitration keep waiting; no request is dropped.
- Starvation bound: with ROUND_ROBIN=1, a continuously valid requester is granted within NUM_REQ-1 other transactions.
- Reset mid-burst: immediate return to IDLE with oreq.valid=0. The memory side is also in reset by system convention.
- The arbiter has no buffering and adds no data-path latency in BUSY; the response path is purely combinational.

Test Plan:
- Single requester, single beat: ireqs[1].valid=1 with addr=0x8000_0040, len=0 at cycle 0; oreq.valid=1 with that addr at cycle 1; oresp ready=1/last=1 at cycle 3 -> iresps[1].ready=1 that cycle, busy=0 at cycle 4, iresps[0] always 0.
- Burst: requester 0 sends a 16-beat read. Memory returns 16 ready beats with last on beat 16 -> iresps[0] carries all 16 data words in order, grant held for all of them, requester 1 (valid from beat 3) gets oreq only 1 idle cycle after beat 16.
- Round-robin contention: both valid continuously, each transaction single-beat -> grant sequence 0,1,0,1, with grant_idx alternating and one IDLE cycle between each.
- Fixed priority (ROUND_ROBIN=0): both continuously valid -> grants always to 0, and requester 1 is starved; document as expected.
- Async reset mid-burst: assert resetn=0 between clock edges at beat 5 of 8 -> oreq.valid=0 and busy=0 immediately without a clock edge. After release, arbitration restarts from rr_ptr=0.
- NUM_REQ=3 wrap: after a grant to index 2, with 0 and 2 both valid -> next grant goes to index 0.
